// File: rtl/mm_block_reader.sv
// Avalon-MM read master: fetches a block of consecutive 32-bit words and streams them in order.
// Reads are only issued while outstanding reads plus buffered words leave room in the FIFO.
module mm_block_reader #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned LEN_W      = 13,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_rem_q, issue_rem_d;
  logic [LEN_W-1:0]  deliver_rem_q, deliver_rem_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic              run, has_credit, accept, push, pop;
  logic [1:0]        unused_addr_lsb;

  assign unused_addr_lsb = base_addr[1:0];

  assign run        = state_q == StRun;
  // Sum never exceeds Depth, so it fits in CntW bits.
  assign has_credit = (outstanding_q + fifo_cnt_q) < Depth;
  assign avm_read   = run && (issue_rem_q != '0) && has_credit;
  assign accept     = avm_read && !avm_waitrequest;
  assign push       = run && avm_readdatavalid;
  assign st_valid   = fifo_cnt_q != '0;
  assign pop        = st_valid && st_ready;
  assign st_data    = st_valid ? fifo_mem[rd_ptr_q] : '0;

  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign busy           = run;
  assign done           = state_q == StFinish;

  assign outstanding_d = outstanding_q + CntW'(accept) - CntW'(push);
  assign fifo_cnt_d    = fifo_cnt_q + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    issue_rem_d   = issue_rem_q;
    deliver_rem_d = deliver_rem_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length != '0) begin
            addr_d        = {base_addr[ADDR_W-1:2], 2'b00};
            issue_rem_d   = length;
            deliver_rem_d = length;
            state_d       = StRun;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StRun: begin
        if (accept) begin
          addr_d      = addr_q + ADDR_W'(4);
          issue_rem_d = issue_rem_q - LEN_W'(1);
        end
        if (pop) begin
          deliver_rem_d = deliver_rem_q - LEN_W'(1);
          if (deliver_rem_q == LEN_W'(1)) state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      issue_rem_q   <= '0;
      deliver_rem_q <= '0;
      outstanding_q <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      issue_rem_q   <= issue_rem_d;
      deliver_rem_q <= deliver_rem_d;
      outstanding_q <= outstanding_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_q + PtrW'(push);
      rd_ptr_q      <= rd_ptr_q + PtrW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= avm_readdata;
  end

endmodule

// File: doc/mm_block_reader.md
# mm_block_reader

Avalon-MM read master that fetches a block of consecutive 32-bit words from a memory-mapped slave, such as the on-chip RAM holding the Tetris playfield, and delivers them in order on a valid/ready stream. It sits between the Avalon interconnect and the display/render logic. The block pipelines reads with credit-based flow control, so the output FIFO can never overflow regardless of sink backpressure.

## Interface
Parameters:
- ADDR_W, 15: master byte-address width; covers 5120 words × 4 bytes.
- LEN_W, 13: width of the word-count field.
- FIFO_DEPTH, 8: output FIFO depth in words; power of two, minimum 2.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] are ignored and treated as 0.
- length  in  LEN_W  number of words to read.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final word has been accepted by the sink.
- avm_address  out  ADDR_W  read byte address, always word aligned.
- avm_read  out  1  read request.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  marks avm_readdata as valid.
- st_data  out  32  stream data.
- st_valid  out  1  stream valid.
- st_ready  in  1  sink ready.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, start=1, length≠0:
  - latch base_addr into addr_cnt (with [1:0] forced to 0);
  - latch length into issue_rem and deliver_rem;
  - go to RUN.
- IDLE, start=1, length=0: go to FINISH with no bus activity.
- start is ignored outside IDLE.
- RUN, issue condition: avm_read=1 whenever issue_rem≠0 and credits≠0.
  - credits = FIFO_DEPTH − (outstanding + fifo_count).
- RUN, acceptance: a read is accepted when avm_read & ~avm_waitrequest. On acceptance:
  - addr_cnt += 4, wrapping modulo 2^ADDR_W;
  - issue_rem −= 1;
  - outstanding += 1.
- RUN, stall: while avm_waitrequest=1, avm_address and avm_read are held stable.
- RUN, read return: on avm_readdatavalid, push avm_readdata into the FIFO and decrement outstanding.
  - Accept, return and pop may all occur in the same cycle. Counters net the simultaneous updates.
- RUN, stream handshake: st_valid & st_ready pops the FIFO and decrements deliver_rem.
- RUN exit: when deliver_rem reaches 0, go to FINISH.
- FINISH: assert done for one cycle, then return to IDLE.
- Invariants:
  - The FIFO never overflows, by construction.
  - avm_readdatavalid outside RUN is ignored.
  - Words are delivered strictly in address order.
- Reset mid-operation:
  - return to IDLE and clear all counters and the FIFO;
  - no done pulse is generated;
  - any in-flight data is discarded, since the interconnect is reset simultaneously.

## Timing
- Reset values:
  - busy=0, done=0, avm_read=0;
  - avm_address=0, avm_byteenable=4'hF;
  - st_valid=0, st_data=0.
- Start to bus: start accepted at cycle N gives busy=1 and avm_read=1 at N+1.
- Read to stream: avm_readdatavalid at cycle M gives st_valid=1 at M+1 (registered FIFO write).
- Steady state: with zero wait states, the slave's 1-cycle read latency and st_ready=1, throughput is 1 word/clk.
  - Total latency for L words = L + 3 cycles from start to done.
- Done: the last handshake at cycle K gives done=1 and busy=0 at K+1.
- Zero length: start with length=0 at N gives done=1 at N+1; busy stays 0.
- Stream rule: st_data is stable while st_valid=1 and st_ready=0.

## Test plan
- Basic read:
  - stimulus: memory model with 1-cycle latency, no waitrequest; base_addr=0x0010, length=4, st_ready=1;
  - response: reads issued to 0x10, 0x14, 0x18 and 0x1C on consecutive cycles; st_data matches the memory words in order; done at start+7.
- Waitrequest:
  - stimulus: waitrequest high for 3 cycles on the second read;
  - response: address 0x14 held for 4 cycles; exactly 4 accepted reads; data order correct.
- Backpressure:
  - stimulus: st_ready=0 for 20 cycles with length=16, FIFO_DEPTH=8;
  - response: at most 8 reads accepted before the sink drains; no data lost; 16 words delivered.
- Zero length, and start while busy:
  - stimulus: length=0; then a start pulse during RUN;
  - response: length=0 gives done 1 cycle later with no avm_read; the mid-RUN start has no effect.
- Address wrap:
  - stimulus: base_addr=0x7FF8, length=4;
  - response: addresses 0x7FF8, 0x7FFC, 0x0000, 0x0004.
- Reset mid-transfer:
  - stimulus: assert reset after 3 of 10 words are delivered;
  - response: next cycle avm_read=0, st_valid=0 and busy=0; no done pulse; a new start then completes normally.
